// File: rtl/meta_pkg.sv
// ---------------------------------------------------------------------------
// meta_pkg
// Shared widths and the metadata write record used by the L1 D-cache
// tag/metadata write scheduler and its input FIFOs.
//   IDX_W        set-index width
//   WAY_W        one-hot way-enable width
//   TAG_W        tag width
//   meta_write_t {idx, way_en, tag} record carried through the scheduler
// ---------------------------------------------------------------------------
package meta_pkg;

    localparam int IDX_W = 6;
    localparam int WAY_W = 1;
    localparam int TAG_W = 20;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WAY_W-1:0] way_en;
        logic [TAG_W-1:0] tag;
    } meta_write_t;

endpackage

// File: rtl/meta_write_fifo.sv
// ---------------------------------------------------------------------------
// meta_write_fifo
// DEPTH-entry FIFO of meta_write_t used to decouple one write requester
// from the scheduler's selection stage.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset (empties the FIFO)
//   push       enqueue request; ignored while full
//   push_data  record to enqueue
//   pop        dequeue request; ignored while empty
//   head       oldest record (valid only while !empty)
//   full       count == DEPTH
//   empty      count == 0
//
// There is no pass-through: a push while full is dropped even if a pop
// happens in the same cycle, and a push into an empty FIFO only becomes
// visible on head in the following cycle.
// ---------------------------------------------------------------------------
module meta_write_fifo
    import meta_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  meta_write_t push_data,
    input  logic        pop,
    output meta_write_t head,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    meta_write_t        mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed between push and pop.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/meta_write_scheduler.sv
// ---------------------------------------------------------------------------
// meta_write_scheduler
// Buffered scheduler for the single L1 D-cache tag/metadata write port.
// Port 0 (refill/MSHR) and port 1 (probe/writeback) each feed a small FIFO;
// one head per cycle is moved into a registered output stage. Port 0 wins
// contention until port 1 has lost STARVE_LIMIT times in a row, after which
// port 1 is forced through.
//
// Ports
//   clock, reset               clock / asynchronous active-high reset
//   io_in_N_valid              requester N has a write
//   io_in_N_ready              FIFO N not full (registered state only)
//   io_in_N_bits_{idx,way_en,tag}  requester N payload
//   io_out_valid               registered write valid to the metadata array
//   io_out_ready               metadata array accepts the write
//   io_out_bits_{idx,way_en,tag}   registered payload
//   io_chosen                  source port of the current output entry
//   io_busy                    any FIFO non-empty or output valid
// ---------------------------------------------------------------------------
module meta_write_scheduler
    import meta_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             io_in_0_valid,
    output logic             io_in_0_ready,
    input  logic [IDX_W-1:0] io_in_0_bits_idx,
    input  logic [WAY_W-1:0] io_in_0_bits_way_en,
    input  logic [TAG_W-1:0] io_in_0_bits_tag,

    input  logic             io_in_1_valid,
    output logic             io_in_1_ready,
    input  logic [IDX_W-1:0] io_in_1_bits_idx,
    input  logic [WAY_W-1:0] io_in_1_bits_way_en,
    input  logic [TAG_W-1:0] io_in_1_bits_tag,

    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [IDX_W-1:0] io_out_bits_idx,
    output logic [WAY_W-1:0] io_out_bits_way_en,
    output logic [TAG_W-1:0] io_out_bits_tag,

    output logic             io_chosen,
    output logic             io_busy
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    meta_write_t      in0_data;
    meta_write_t      in1_data;
    meta_write_t      head0;
    meta_write_t      head1;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic             head0_v;
    logic             head1_v;

    logic             load;
    logic             sel1;
    logic             pop0;
    logic             pop1;

    meta_write_t      out_q;
    logic             out_valid_q;
    logic             chosen_q;

    logic [SC_W-1:0]  starve_cnt;
    logic [SC_W-1:0]  starve_cnt_d;

    assign in0_data = '{idx: io_in_0_bits_idx, way_en: io_in_0_bits_way_en, tag: io_in_0_bits_tag};
    assign in1_data = '{idx: io_in_1_bits_idx, way_en: io_in_1_bits_way_en, tag: io_in_1_bits_tag};

    meta_write_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clock     (clock),
        .reset     (reset),
        .push      (io_in_0_valid),
        .push_data (in0_data),
        .pop       (pop0),
        .head      (head0),
        .full      (full0),
        .empty     (empty0)
    );

    meta_write_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clock     (clock),
        .reset     (reset),
        .push      (io_in_1_valid),
        .push_data (in1_data),
        .pop       (pop1),
        .head      (head1),
        .full      (full1),
        .empty     (empty1)
    );

    // Ready depends only on FIFO occupancy, never on io_out_ready.
    assign io_in_0_ready = !full0;
    assign io_in_1_ready = !full1;

    assign head0_v = !empty0;
    assign head1_v = !empty1;

    assign load = !out_valid_q || io_out_ready;

    // Port 1 wins when it is alone or when it has been starved long enough.
    assign sel1 = head1_v && (!head0_v || (starve_cnt == SC_W'(STARVE_LIMIT)));
    assign pop0 = load && head0_v && !sel1;
    assign pop1 = load && sel1;

    always_comb begin
        starve_cnt_d = starve_cnt;
        if (load && head0_v && head1_v && !sel1) begin
            if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt_d = starve_cnt + 1'b1;
            end
        end else if (pop1) begin
            starve_cnt_d = '0;
        end else if (empty1) begin
            starve_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_d;
        end
    end

    // Output stage: bits and chosen hold while stalled and when going idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            chosen_q    <= 1'b0;
        end else if (load) begin
            if (head0_v || head1_v) begin
                out_q       <= sel1 ? head1 : head0;
                out_valid_q <= 1'b1;
                chosen_q    <= sel1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign io_out_valid       = out_valid_q;
    assign io_out_bits_idx    = out_q.idx;
    assign io_out_bits_way_en = out_q.way_en;
    assign io_out_bits_tag    = out_q.tag;
    assign io_chosen          = chosen_q;
    assign io_busy            = head0_v || head1_v || out_valid_q;

endmodule

// File: tb/tb_meta_write_scheduler.sv
module tb_meta_write_scheduler;

    logic        clock;
    logic        reset;
    logic        io_in_0_valid;
    logic        io_in_0_ready;
    logic [5:0]  io_in_0_bits_idx;
    logic [0:0]  io_in_0_bits_way_en;
    logic [19:0] io_in_0_bits_tag;
    logic        io_in_1_valid;
    logic        io_in_1_ready;
    logic [5:0]  io_in_1_bits_idx;
    logic [0:0]  io_in_1_bits_way_en;
    logic [19:0] io_in_1_bits_tag;
    logic        io_out_valid;
    logic        io_out_ready;
    logic [5:0]  io_out_bits_idx;
    logic [0:0]  io_out_bits_way_en;
    logic [19:0] io_out_bits_tag;
    logic        io_chosen;
    logic        io_busy;

    int checks   = 0;
    int failures = 0;

    meta_write_scheduler #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock               (clock),
        .reset               (reset),
        .io_in_0_valid       (io_in_0_valid),
        .io_in_0_ready       (io_in_0_ready),
        .io_in_0_bits_idx    (io_in_0_bits_idx),
        .io_in_0_bits_way_en (io_in_0_bits_way_en),
        .io_in_0_bits_tag    (io_in_0_bits_tag),
        .io_in_1_valid       (io_in_1_valid),
        .io_in_1_ready       (io_in_1_ready),
        .io_in_1_bits_idx    (io_in_1_bits_idx),
        .io_in_1_bits_way_en (io_in_1_bits_way_en),
        .io_in_1_bits_tag    (io_in_1_bits_tag),
        .io_out_valid        (io_out_valid),
        .io_out_ready        (io_out_ready),
        .io_out_bits_idx     (io_out_bits_idx),
        .io_out_bits_way_en  (io_out_bits_way_en),
        .io_out_bits_tag     (io_out_bits_tag),
        .io_chosen           (io_chosen),
        .io_busy             (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v0;
        logic [5:0]  idx0;
        logic [19:0] tag0;
        logic        v1;
        logic [5:0]  idx1;
        logic [19:0] tag1;
        logic        ordy;
        logic        e_ov;
        logic        e_ch;
        logic [5:0]  e_idx;
        logic [19:0] e_tag;
        logic        e_rdy0;
        logic        e_rdy1;
        logic        e_busy;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        io_in_0_valid = 1'b0;
        io_in_1_valid = 1'b0;
        io_out_ready  = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        drive_idle();
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!io_busy) done = 1'b1;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    logic exp_a [10];
    logic exp_b [11];

    initial begin
        reset               = 1'b1;
        io_in_0_valid       = 1'b0;
        io_in_0_bits_idx    = '0;
        io_in_0_bits_way_en = 1'b1;
        io_in_0_bits_tag    = '0;
        io_in_1_valid       = 1'b0;
        io_in_1_bits_idx    = '0;
        io_in_1_bits_way_en = 1'b1;
        io_in_1_bits_tag    = '0;
        io_out_ready        = 1'b1;

        //           v0  idx0   tag0       v1  idx1   tag1       ordy  ov  ch  idx    tag        rdy0 rdy1 busy
        vt[0]  = '{1'b0, 6'h00, 20'h00000, 1'b1, 6'h2A, 20'hABCDE, 1'b1, 1'b0, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b1, 1'b1};
        vt[1]  = '{1'b0, 6'h00, 20'h00000, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b1, 1'b1, 6'h2A, 20'hABCDE, 1'b1, 1'b1, 1'b1};
        vt[2]  = '{1'b0, 6'h00, 20'h00000, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b0, 1'b1, 6'h2A, 20'hABCDE, 1'b1, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 6'h01, 20'h11111, 1'b0, 6'h00, 20'h00000, 1'b0, 1'b0, 1'b1, 6'h2A, 20'hABCDE, 1'b1, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 6'h02, 20'h22222, 1'b0, 6'h00, 20'h00000, 1'b0, 1'b1, 1'b0, 6'h01, 20'h11111, 1'b1, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 6'h03, 20'h33333, 1'b0, 6'h00, 20'h00000, 1'b0, 1'b1, 1'b0, 6'h01, 20'h11111, 1'b0, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 6'h04, 20'h44444, 1'b0, 6'h00, 20'h00000, 1'b0, 1'b1, 1'b0, 6'h01, 20'h11111, 1'b0, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 6'h04, 20'h44444, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b1, 1'b0, 6'h02, 20'h22222, 1'b1, 1'b1, 1'b1};
        vt[8]  = '{1'b1, 6'h04, 20'h44444, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b1, 1'b0, 6'h03, 20'h33333, 1'b1, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 6'h00, 20'h00000, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b1, 1'b0, 6'h04, 20'h44444, 1'b1, 1'b1, 1'b1};
        vt[10] = '{1'b0, 6'h00, 20'h00000, 1'b0, 6'h00, 20'h00000, 1'b1, 1'b0, 1'b0, 6'h04, 20'h44444, 1'b1, 1'b1, 1'b0};

        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        #2;
        chk("rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, io_busy},      32'd0);
        chk("rst_ready0",    {31'd0, io_in_0_ready}, 32'd1);
        chk("rst_ready1",    {31'd0, io_in_1_ready}, 32'd1);
        chk("rst_chosen",    {31'd0, io_chosen},    32'd0);
        chk("rst_idx",       {26'd0, io_out_bits_idx}, 32'd0);
        chk("rst_tag",       {12'd0, io_out_bits_tag}, 32'd0);
        #10;
        reset = 1'b0;

        // Single port-1 write, then port-0 backpressure and in-order drain
        for (int i = 0; i < 11; i++) begin
            io_in_0_valid    = vt[i].v0;
            io_in_0_bits_idx = vt[i].idx0;
            io_in_0_bits_tag = vt[i].tag0;
            io_in_1_valid    = vt[i].v1;
            io_in_1_bits_idx = vt[i].idx1;
            io_in_1_bits_tag = vt[i].tag1;
            io_out_ready     = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d_out_valid", i), {31'd0, io_out_valid},  {31'd0, vt[i].e_ov});
            chk($sformatf("vec%0d_chosen", i),    {31'd0, io_chosen},     {31'd0, vt[i].e_ch});
            chk($sformatf("vec%0d_idx", i),       {26'd0, io_out_bits_idx}, {26'd0, vt[i].e_idx});
            chk($sformatf("vec%0d_tag", i),       {12'd0, io_out_bits_tag}, {12'd0, vt[i].e_tag});
            chk($sformatf("vec%0d_ready0", i),    {31'd0, io_in_0_ready}, {31'd0, vt[i].e_rdy0});
            chk($sformatf("vec%0d_ready1", i),    {31'd0, io_in_1_ready}, {31'd0, vt[i].e_rdy1});
            chk($sformatf("vec%0d_busy", i),      {31'd0, io_busy},       {31'd0, vt[i].e_busy});
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_way", i), {31'd0, io_out_bits_way_en}, 32'd1);
            end
        end
        drive_idle();

        // Anti-starvation with both ports continuously requesting
        io_in_0_bits_idx = 6'h10;
        io_in_0_bits_tag = 20'h0F0F0;
        io_in_1_bits_idx = 6'h20;
        io_in_1_bits_tag = 20'hF0F0F;
        io_out_ready     = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            io_in_0_valid = 1'b1;
            io_in_1_valid = 1'b1;
            tick();
            if (e >= 1) begin
                chk($sformatf("starveA_e%0d_valid", e), {31'd0, io_out_valid}, 32'd1);
                chk($sformatf("starveA_e%0d_chosen", e), {31'd0, io_chosen}, {31'd0, exp_a[e-1]});
                chk($sformatf("starveA_e%0d_idx", e), {26'd0, io_out_bits_idx},
                    exp_a[e-1] ? 32'h20 : 32'h10);
            end
        end
        wait_idle("starveA_drain");

        // Port 1 empties after a grant; the next contention needs 4 fresh port-0 wins
        for (int e = 0; e <= 11; e++) begin
            io_in_0_valid = 1'b1;
            io_in_1_valid = (e == 0 || e == 6);
            io_out_ready  = 1'b1;
            tick();
            if (e >= 1) begin
                chk($sformatf("starveB_e%0d_chosen", e), {31'd0, io_chosen}, {31'd0, exp_b[e-1]});
                chk($sformatf("starveB_e%0d_idx", e), {26'd0, io_out_bits_idx},
                    exp_b[e-1] ? 32'h20 : 32'h10);
            end
        end
        wait_idle("starveB_drain");

        // Mid-stream reset with both FIFOs full and the output occupied
        io_out_ready  = 1'b0;
        io_in_0_valid = 1'b1;
        io_in_1_valid = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_out_valid", {31'd0, io_out_valid},  32'd1);
        chk("pre_rst_ready0",    {31'd0, io_in_0_ready}, 32'd0);
        chk("pre_rst_ready1",    {31'd0, io_in_1_ready}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("mid_rst_busy",      {31'd0, io_busy},      32'd0);
        io_in_0_valid = 1'b0;
        io_in_1_valid = 1'b0;
        tick();
        chk("mid_rst_ready0", {31'd0, io_in_0_ready}, 32'd1);
        chk("mid_rst_ready1", {31'd0, io_in_1_ready}, 32'd1);
        #2;
        reset        = 1'b0;
        io_out_ready = 1'b1;
        tick();
        chk("post_rst_out_valid", {31'd0, io_out_valid}, 32'd0);
        chk("post_rst_busy",      {31'd0, io_busy},      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
